// File: rtl/sseg_pkg.sv
// sseg_pkg: shared glyph table, blank constant and brightness-compare helper for the sseg display driver.
package sseg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  function automatic int bright_lsb(input int ticks);
    return $clog2(ticks) - 4;
  endfunction
endpackage

// File: rtl/sseg_decode.sv
// sseg_decode: nibble to active-high {g,f,e,d,c,b,a}; BCD mode blanks 10..15.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);
  always_comb seg = (hex_mode || nibble < 4'd10) ? GLYPH[nibble] : SEG_BLANK;
endmodule

// File: rtl/sseg_mux_n.sv
// sseg_mux_n: N-digit multiplexed seven-segment driver with frame-synchronous shadowing, LZ blanking and PWM.
module sseg_mux_n
  import sseg_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_DIGIT = 1024,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  hex_mode_in,
  input  logic                  blank_lz_in,
  input  logic [3:0]            bright_in,
  output logic [DIGITS-1:0]     sseg_a_o,
  output logic [6:0]            sseg_c_o,
  output logic                  sseg_dp_o,
  output logic                  frame_o
);
  localparam int TW = $clog2(TICKS_PER_DIGIT);
  localparam int IW = $clog2(DIGITS);
  localparam int BL = bright_lsb(TICKS_PER_DIGIT);
  localparam logic AL = ACTIVE_LOW != 0;
  logic [TW-1:0] tick;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] sh_bcd;
  logic [DIGITS-1:0] sh_dp, zeros, lz_mask, an_nxt;
  logic sh_hex, sh_lz, tick_end, frame_end, blank, an_on, dp_nxt;
  logic [3:0] sh_bright, nibble;
  logic [6:0] glyph, seg_nxt;
  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_zero
    assign zeros[g] = sh_bcd[4*g +: 4] == 4'd0;
  end
  sseg_decode u_decode (.nibble(nibble), .hex_mode(sh_hex), .seg(glyph));
  // a digit is a leading zero when it and every digit above it are zero
  always_comb begin
    tick_end  = tick == TW'(TICKS_PER_DIGIT - 1);
    frame_end = tick_end && idx == IW'(DIGITS - 1);
    nibble    = sh_bcd[4*idx +: 4];
    lz_mask   = zeros | ((DIGITS'(1) << idx) - DIGITS'(1));
    blank     = sh_lz && idx != '0 && &lz_mask;
    an_on     = tick != '0 && tick[TW-1:BL] <= sh_bright && (!blank || sh_dp[idx]);
    an_nxt    = an_on ? DIGITS'(1) << idx : '0;
    seg_nxt   = an_on && !blank ? glyph : SEG_BLANK;
    dp_nxt    = an_on && sh_dp[idx];
  end
  always_ff @(posedge clk) begin
    if (!rst_n || frame_end) begin
      sh_bcd    <= bcd_in;
      sh_dp     <= dp_in;
      sh_hex    <= hex_mode_in;
      sh_lz     <= blank_lz_in;
      sh_bright <= bright_in;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick      <= '0;
      idx       <= '0;
      frame_o   <= 1'b0;
      sseg_a_o  <= {DIGITS{AL}};
      sseg_c_o  <= {7{AL}};
      sseg_dp_o <= AL;
    end else begin
      tick      <= tick + TW'(1);
      if (tick_end) idx <= frame_end ? '0 : idx + IW'(1);
      frame_o   <= frame_end;
      sseg_a_o  <= an_nxt ^ {DIGITS{AL}};
      sseg_c_o  <= seg_nxt ^ {7{AL}};
      sseg_dp_o <= dp_nxt ^ AL;
    end
  end
endmodule

// File: tb/tb_sseg_mux_n.sv
// tb_sseg_mux_n: scoreboard bench; stimulus queues per-cycle expected pin states, a monitor pops and compares.
module tb_sseg_mux_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst4, hex4, lz4, fr4, dpo4;
  logic [15:0] bcd4;
  logic [3:0] dp4, br4, a4;
  logic [6:0] c4;
  logic rst8, hex8, lz8, fr8, dpo8;
  logic [31:0] bcd8;
  logic [7:0] dp8, a8;
  logic [3:0] br8;
  logic [6:0] c8;
  sseg_mux_n #(.DIGITS(4), .TICKS_PER_DIGIT(16), .ACTIVE_LOW(1)) dut4 (
    .clk(clk), .rst_n(rst4), .bcd_in(bcd4), .dp_in(dp4), .hex_mode_in(hex4), .blank_lz_in(lz4),
    .bright_in(br4), .sseg_a_o(a4), .sseg_c_o(c4), .sseg_dp_o(dpo4), .frame_o(fr4));
  sseg_mux_n #(.DIGITS(8), .TICKS_PER_DIGIT(16), .ACTIVE_LOW(1)) dut8 (
    .clk(clk), .rst_n(rst8), .bcd_in(bcd8), .dp_in(dp8), .hex_mode_in(hex8), .blank_lz_in(lz8),
    .bright_in(br8), .sseg_a_o(a8), .sseg_c_o(c8), .sseg_dp_o(dpo8), .frame_o(fr8));
  typedef struct packed {
    logic        sel;
    logic [7:0]  a;
    logic [6:0]  c;
    logic        dp;
    logic        fr;
    logic [15:0] tag;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [16:0] got, want;
  int compared = 0, mismatched = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      me   = q.pop_front();
      got  = me.sel ? {a8, c8, dpo8, fr8} : {4'h0, a4, c4, dpo4, fr4};
      want = {me.a, me.c, me.dp, me.fr};
      compared++;
      if (got !== want) begin
        mismatched++;
        $display("FAIL tag%0d: got a=%h c=%h dp=%b fr=%b, want a=%h c=%h dp=%b fr=%b",
                 me.tag, got[16:9], got[8:2], got[1], got[0], me.a, me.c, me.dp, me.fr);
      end
    end
  end
  task automatic push(input logic s, input int nd, input int d, input int t, input logic en,
                      input logic [6:0] seg, input logic dpb, input logic [3:0] br, input int tag);
    exp_t e;
    logic on;
    logic [7:0] full;
    full  = 8'((1 << nd) - 1);
    on    = en && t != 0 && t <= int'(br);
    e.sel = s;
    e.a   = on ? full & ~8'(1 << d) : full;
    e.c   = on ? ~seg : 7'h7F;
    e.dp  = !(on && dpb);
    e.fr  = d == nd - 1 && t == 15;
    e.tag = 16'(tag);
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic slot(input logic s, input int nd, input int d, input logic en, input logic [6:0] seg,
                      input logic dpb, input logic [3:0] br, input int tag);
    for (int t = 0; t < 16; t++) push(s, nd, d, t, en, seg, dpb, br, tag);
  endtask
  task automatic frame4(input logic [3:0][6:0] segs, input logic [3:0] en, input logic [3:0] dpm,
                        input logic [3:0] br, input int tag);
    for (int d = 0; d < 4; d++) slot(1'b0, 4, d, en[d], segs[d], dpm[d], br, tag);
  endtask
  task automatic reset_dut(input logic s, input int n, input int tag);
    if (s) rst8 = 1'b0; else rst4 = 1'b0;
    for (int i = 0; i < n; i++) push(s, s ? 8 : 4, 0, 0, 1'b0, 7'h00, 1'b0, 4'd0, tag);
    if (s) rst8 = 1'b1; else rst4 = 1'b1;
  endtask
  initial begin
    rst4 = 0; bcd4 = '0; dp4 = '0; hex4 = 0; lz4 = 0; br4 = 4'd15;
    rst8 = 0; bcd8 = '0; dp8 = '0; hex8 = 0; lz8 = 0; br8 = 4'd15;
    @(negedge clk);
    bcd4 = 16'h1234;
    reset_dut(1'b0, 3, 100);
    frame4({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF, 4'h0, 4'd15, 101);
    frame4({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF, 4'h0, 4'd15, 102);
    bcd4 = 16'h0070; lz4 = 1;
    reset_dut(1'b0, 2, 200);
    lz4 = 0;
    frame4({7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0011, 4'h0, 4'd15, 201);
    frame4({7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'hF, 4'h0, 4'd15, 202);
    lz4 = 1; dp4 = 4'b1000;
    reset_dut(1'b0, 2, 210);
    frame4({7'h00, 7'h00, 7'h07, 7'h3F}, 4'b1011, 4'b1000, 4'd15, 211);
    lz4 = 0; dp4 = 4'h0; bcd4 = 16'hABCF; hex4 = 1;
    reset_dut(1'b0, 2, 300);
    frame4({7'h77, 7'h7C, 7'h39, 7'h71}, 4'hF, 4'h0, 4'd15, 301);
    hex4 = 0;
    reset_dut(1'b0, 2, 310);
    frame4({7'h00, 7'h00, 7'h00, 7'h00}, 4'hF, 4'h0, 4'd15, 311);
    bcd4 = 16'h1234; br4 = 4'd7;
    reset_dut(1'b0, 2, 400);
    frame4({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF, 4'h0, 4'd7, 401);
    br4 = 4'd3; dp4 = 4'b0101;
    reset_dut(1'b0, 2, 410);
    frame4({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF, 4'b0101, 4'd3, 411);
    dp4 = 4'h0; br4 = 4'd15; bcd4 = 16'h1111;
    reset_dut(1'b0, 2, 500);
    slot(1'b0, 4, 0, 1'b1, 7'h06, 1'b0, 4'd15, 501);
    bcd4 = 16'h2222;
    for (int d = 1; d < 4; d++) slot(1'b0, 4, d, 1'b1, 7'h06, 1'b0, 4'd15, 502);
    frame4({7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'hF, 4'h0, 4'd15, 503);
    bcd8 = 32'h7654_3210;
    reset_dut(1'b1, 2, 600);
    slot(1'b1, 8, 0, 1'b1, 7'h3F, 1'b0, 4'd15, 601);
    slot(1'b1, 8, 1, 1'b1, 7'h06, 1'b0, 4'd15, 601);
    slot(1'b1, 8, 2, 1'b1, 7'h5B, 1'b0, 4'd15, 601);
    slot(1'b1, 8, 3, 1'b1, 7'h4F, 1'b0, 4'd15, 601);
    slot(1'b1, 8, 4, 1'b1, 7'h66, 1'b0, 4'd15, 601);
    for (int t = 0; t < 5; t++) push(1'b1, 8, 5, t, 1'b1, 7'h6D, 1'b0, 4'd15, 602);
    bcd8 = 32'h1111_1111;
    rst8 = 0;
    push(1'b1, 8, 0, 0, 1'b0, 7'h00, 1'b0, 4'd0, 603);
    bcd8 = 32'h0123_4567;
    reset_dut(1'b1, 2, 604);
    slot(1'b1, 8, 0, 1'b1, 7'h07, 1'b0, 4'd15, 605);
    slot(1'b1, 8, 1, 1'b1, 7'h7D, 1'b0, 4'd15, 605);
    slot(1'b1, 8, 2, 1'b1, 7'h6D, 1'b0, 4'd15, 605);
    slot(1'b1, 8, 3, 1'b1, 7'h66, 1'b0, 4'd15, 605);
    slot(1'b1, 8, 4, 1'b1, 7'h4F, 1'b0, 4'd15, 605);
    slot(1'b1, 8, 5, 1'b1, 7'h5B, 1'b0, 4'd15, 605);
    slot(1'b1, 8, 6, 1'b1, 7'h06, 1'b0, 4'd15, 605);
    slot(1'b1, 8, 7, 1'b1, 7'h3F, 1'b0, 4'd15, 605);
    @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
